// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the ROM arbiter: per-requester request/address,
// combinational grants, read-valid pulses and the shared registered read data.
interface rom_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;

  modport master (
    output req0, req1, addr0, addr1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for a shared LAT-cycle ROM: rvalid follows the grant edge by LAT+1 edges, one read per cycle;
// requesters hold req until gnt, en=0 drains in-flight reads. Define ROM_ARB_RR_EN for round-robin, else requester 0 has fixed priority.
module rom_arbiter #(
  parameter int AW  = 4,
  parameter int DW  = 8,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  rom_arbiter_if.slave  rq,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          busy,
  output logic          idle
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [LAT:0]  tag_vld;
  logic [LAT:0]  tag_id;
  logic [DW-1:0] rdata;
  logic          rvalid0;
  logic          rvalid1;
  logic          arb_ok;
  logic          gnt0;
  logic          gnt1;
  logic          xfer;

  assign arb_ok = (state == RUN) && en;

`ifdef ROM_ARB_RR_EN
  // rr_pri1=1 means requester 1 wins the next tie; it flips only on a real transfer.
  logic rr_pri1;

  assign gnt0 = arb_ok && rq.req0 && (!rq.req1 || !rr_pri1);
  assign gnt1 = arb_ok && rq.req1 && (!rq.req0 ||  rr_pri1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pri1 <= 1'b0;
    end else if (xfer) begin
      rr_pri1 <= gnt0;
    end
  end
`else
  assign gnt0 = arb_ok && rq.req0;
  assign gnt1 = arb_ok && rq.req1 && !rq.req0;
`endif

  assign xfer       = gnt0 || gnt1;
  assign busy       = (|tag_vld) || rvalid0 || rvalid1;
  assign idle       = (state == IDLE);

  assign rq.gnt0    = gnt0;
  assign rq.gnt1    = gnt1;
  assign rq.rvalid0 = rvalid0;
  assign rq.rvalid1 = rvalid1;
  assign rq.rdata   = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN: begin
          if (en)         state <= RUN;
          else if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag stage k holds the read issued k edges ago; the last stage lines up with valid rom_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_id   <= '0;
      rom_addr <= '0;
      rdata    <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      tag_vld <= {tag_vld[LAT-1:0], xfer};
      tag_id  <= {tag_id[LAT-1:0], gnt1};
      if (xfer) begin
        rom_addr <= gnt1 ? rq.addr1 : rq.addr0;
      end
      rvalid0 <= tag_vld[LAT] && !tag_id[LAT];
      rvalid1 <= tag_vld[LAT] &&  tag_id[LAT];
      if (tag_vld[LAT]) begin
        rdata <= rom_dout;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
  a_gnt_req:    assert property (@(posedge clk) disable iff (!rst_n) (!gnt0 || rq.req0) && (!gnt1 || rq.req1));

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          busy;
  logic          idle;

  int checks = 0;
  int errors = 0;

  rom_arbiter_if #(.AW(AW), .DW(DW)) rq ();

  rom_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rq       (rq),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .busy     (busy),
    .idle     (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: 0x10|a for a in 0..6 and 0xF, zero elsewhere.
  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return ((a <= 4'd6) || (a == 4'hF)) ? (8'h10 | {4'h0, a}) : 8'h00;
  endfunction

  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_val(rom_addr);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_dout = rom_pipe[LAT-1];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en, r0, r1;
    logic [3:0] a0, a1;
    logic       g0, g1, v0, v1;
    logic [7:0] rd;
    logic       idl, bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en_i, r0, r1, input logic [3:0] a0, a1,
                     input logic g0, g1, v0, v1, input logic [7:0] rd, input logic idl, bsy);
    vec_t v;
    v.en = en_i; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd; v.idl = idl; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n_rv;
    bit  idle_seen;
    logic [7:0] exp_q [3];

    // Single read of 0x2 (rows 0-7): grant in row 1, rvalid0 five rows later.
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h00,H,L);
    add(H,H,L,4'h2,4'h0, H,L,L,L,8'h00,L,L);
    for (int k = 0; k < 4; k++) add(H,L,L,4'h0,4'h0, L,L,L,L,8'h00,L,H);
    add(H,L,L,4'h0,4'h0, L,L,H,L,8'h12,L,H);
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h12,L,L);
    // Back-to-back 0xF then 0xA (rows 8-15).
    add(H,H,L,4'hF,4'h0, H,L,L,L,8'h12,L,L);
    add(H,H,L,4'hA,4'h0, H,L,L,L,8'h12,L,H);
    for (int k = 0; k < 3; k++) add(H,L,L,4'h0,4'h0, L,L,L,L,8'h12,L,H);
    add(H,L,L,4'h0,4'h0, L,L,H,L,8'h1F,L,H);
    add(H,L,L,4'h0,4'h0, L,L,H,L,8'h00,L,H);
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h00,L,L);
    // Streaming req1 addresses 0..7 (rows 16-29).
    for (int k = 0; k < 8; k++)
      add(H,L,H,4'h0,4'(k), L,H,L,(k >= 5),
          (k >= 5) ? 8'(8'h10 + k - 5) : 8'h00, L, (k != 0));
    for (int j = 0; j < 5; j++)
      add(H,L,L,4'h0,4'h0, L,L,L,H, (j < 4) ? 8'(8'h13 + j) : 8'h00, L,H);
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h00,L,L);
    // Contention 0x1 vs 0x5 for four cycles (rows 30-39).
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
      add(H,H,H,4'h1,4'h5, (k % 2 == 0),(k % 2 == 1),L,L,8'h00,L,(k != 0));
`else
      add(H,H,H,4'h1,4'h5, H,L,L,L,8'h00,L,(k != 0));
`endif
    end
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h00,L,H);
    for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_RR_EN
      add(H,L,L,4'h0,4'h0, L,L,(k % 2 == 0),(k % 2 == 1),(k % 2 == 0) ? 8'h11 : 8'h15,L,H);
`else
      add(H,L,L,4'h0,4'h0, L,L,H,L,8'h11,L,H);
`endif
    end
`ifdef ROM_ARB_RR_EN
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h15,L,L);
`else
    add(H,L,L,4'h0,4'h0, L,L,L,L,8'h11,L,L);
`endif

    // Reset, with requests and enable pending to show grants stay low.
    rst_n = 1'b1; en = 1'b1;
    rq.req0 = 1'b1; rq.req1 = 1'b1; rq.addr0 = '0; rq.addr1 = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst gnt0", rq.gnt0, L);
    chk1("rst gnt1", rq.gnt1, L);
    chk1("rst rvalid0", rq.rvalid0, L);
    chk1("rst rvalid1", rq.rvalid1, L);
    chk8("rst rdata", rq.rdata, 8'h00);
    chk8("rst rom_addr", {4'h0, rom_addr}, 8'h00);
    chk1("rst busy", busy, L);
    chk1("rst idle", idle, H);
    rq.req0 = 1'b0; rq.req1 = 1'b0; en = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en; rq.req0 = tbl[i].r0; rq.req1 = tbl[i].r1;
      rq.addr0 = tbl[i].a0; rq.addr1 = tbl[i].a1;
      #1;
      chk1($sformatf("row%0d gnt0", i), rq.gnt0, tbl[i].g0);
      chk1($sformatf("row%0d gnt1", i), rq.gnt1, tbl[i].g1);
      chk1($sformatf("row%0d rvalid0", i), rq.rvalid0, tbl[i].v0);
      chk1($sformatf("row%0d rvalid1", i), rq.rvalid1, tbl[i].v1);
      chk8($sformatf("row%0d rdata", i), rq.rdata, tbl[i].rd);
      chk1($sformatf("row%0d idle", i), idle, tbl[i].idl);
      chk1($sformatf("row%0d busy", i), busy, tbl[i].bsy);
      step();
    end
`ifdef ROM_ARB_RR_EN
    chk8("rom_addr held", {4'h0, rom_addr}, 8'h05);
`else
    chk8("rom_addr held", {4'h0, rom_addr}, 8'h01);
`endif

    // Drain: three grants, then en drops with req0 still pending.
    en = 1'b1; rq.req0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rq.addr0 = 4'(k + 1);
      #1;
      chk1($sformatf("drain grant%0d", k), rq.gnt0, H);
      step();
    end
    en = 1'b0; rq.addr0 = 4'h4;
    exp_q = '{8'h11, 8'h12, 8'h13};
    n_rv = 0;
    idle_seen = 1'b0;
    for (int c = 0; c < 20 && !idle_seen; c++) begin
      #1;
      chk1($sformatf("drain c%0d no gnt", c), rq.gnt0 || rq.gnt1, L);
      chk1($sformatf("drain c%0d rvalid1", c), rq.rvalid1, L);
      if (rq.rvalid0) begin
        if (n_rv < 3) chk8($sformatf("drain rdata%0d", n_rv), rq.rdata, exp_q[n_rv]);
        n_rv++;
      end
      if (idle) idle_seen = 1'b1;
      else      step();
    end
    chk1("drain reached idle", idle_seen, H);
    chk8("drain response count", 8'(n_rv), 8'd3);
    chk1("drain busy at idle", busy, L);
    rq.req0 = 1'b0;

    // Reset one cycle after granting 0xF: the read must vanish.
    en = 1'b1;
    step();
    rq.req0 = 1'b1; rq.addr0 = 4'hF;
    #1;
    chk1("rstmid grant", rq.gnt0, H);
    step();
    rq.req0 = 1'b0;
    step();
    rst_n = 1'b0; rq.req0 = 1'b1;
    #1;
    chk1("rstmid gnt0 in reset", rq.gnt0, L);
    chk1("rstmid busy in reset", busy, L);
    chk8("rstmid rom_addr", {4'h0, rom_addr}, 8'h00);
    step();
    rst_n = 1'b1; rq.req0 = 1'b0; en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk1($sformatf("rstmid c%0d rvalid0", c), rq.rvalid0, L);
      chk8($sformatf("rstmid c%0d rdata", c), rq.rdata, 8'h00);
      chk1($sformatf("rstmid c%0d idle", c), idle, H);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
